snn_neuron_scheduler: RTL

Time-multiplexed scheduler for the tiny SNN. It shares one leaky integrate-and-fire (LIF) update datapath among NUM_NEURONS virtual neurons. Membrane potentials live in an internal register file. On each accepted timestep the block walks the neurons round-robin, one per cycle, and returns a spike vector. It sits between the top-level pin wrapper (input currents, config) and the spike outputs.

---
 rtl/snn_pkg.sv | 17 +
 rtl/snn_neuron_scheduler_if.sv | 30 +++
 rtl/snn_lif_core.sv | 29 ++
 rtl/snn_neuron_scheduler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the tiny SNN neuron scheduler: FSM state encoding,
// default datapath width, reset values of the config registers and the
// refractory period length.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int         VW_DEFAULT     = 8;
    localparam logic [7:0] RST_THRESHOLD  = 8'd128;
    localparam logic [2:0] RST_LEAK       = 3'd1;
    localparam logic [1:0] REFRACTORY_LEN = 2'd2;

endpackage : snn_pkg

// File: rtl/snn_neuron_scheduler_if.sv
// Step/config/result bundle between the pin wrapper and the neuron scheduler.
// master drives step requests and configuration; slave is the scheduler.
interface snn_neuron_scheduler_if
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int VW          = VW_DEFAULT
);

    logic                      step_valid;
    logic                      step_ready;
    logic [NUM_NEURONS*VW-1:0] current;
    logic                      cfg_we;
    logic [VW-1:0]             cfg_threshold;
    logic [2:0]                cfg_leak;
    logic [NUM_NEURONS-1:0]    spikes;
    logic                      done;
    logic                      busy;

    modport master (
        output step_valid, current, cfg_we, cfg_threshold, cfg_leak,
        input  step_ready, spikes, done, busy
    );

    modport slave (
        input  step_valid, current, cfg_we, cfg_threshold, cfg_leak,
        output step_ready, spikes, done, busy
    );

endinterface : snn_neuron_scheduler_if

// File: rtl/snn_lif_core.sv
// Combinational leaky integrate-and-fire update for one neuron:
// v_next = sat(v - (v >> leak) + i_cur), spike = (v_next >= threshold).
// v_next is the saturated potential before any reset-on-spike.
module snn_lif_core #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] v,
    input  logic [VW-1:0] i_cur,
    input  logic [VW-1:0] threshold,
    input  logic [2:0]    leak,
    output logic [VW-1:0] v_next,
    output logic          spike
);

    // One extra bit holds the carry of the add so saturation can be detected.
    logic [VW:0] sum;

    // Leak, integrate, saturate at all-ones, then compare against threshold.
    always_comb begin
        sum = {1'b0, v - (v >> leak)} + {1'b0, i_cur};
        if (sum[VW]) begin
            v_next = '1;
        end else begin
            v_next = sum[VW-1:0];
        end
        spike = (v_next >= threshold);
    end

endmodule : snn_lif_core

// File: rtl/snn_neuron_scheduler.sv
// Time-multiplexed LIF scheduler: one shared snn_lif_core walks NUM_NEURONS
// virtual neurons round-robin, one per cycle, per accepted timestep.
// Optional feature: define SNN_REFRACTORY_EN to give every neuron a 2-step
// refractory period after it spikes (potential held at 0, current ignored).
module snn_neuron_scheduler #(
    parameter int             NUM_NEURONS   = 4,
    parameter int             VW            = snn_pkg::VW_DEFAULT,
    parameter logic [VW-1:0]  RST_THRESHOLD = snn_pkg::RST_THRESHOLD,
    parameter logic [2:0]     RST_LEAK      = snn_pkg::RST_LEAK
) (
    input  logic                  clk,
    input  logic                  reset,
    snn_neuron_scheduler_if.slave bus
);

    import snn_pkg::*;

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_UPDATE = UPDATE;
    localparam logic [1:0] S_DONE   = DONE;

    localparam int             IW       = $clog2(NUM_NEURONS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_NEURONS - 1);

    logic [1:0]             state;
    logic [IW-1:0]          idx;
    logic [VW-1:0]          thr_q;
    logic [2:0]             leak_q;
    logic [NUM_NEURONS-1:0] work_q;
    logic [NUM_NEURONS-1:0] spikes_q;
    logic [VW-1:0]          v_mem      [NUM_NEURONS];
    logic [VW-1:0]          cur_shadow [NUM_NEURONS];

    logic                   step_accept;
    logic                   core_spike;
    logic [VW-1:0]          core_v_next;
    logic [VW-1:0]          v_wr;
    logic                   spike_bit;
    logic [NUM_NEURONS-1:0] work_next;

`ifdef SNN_REFRACTORY_EN
    logic [1:0]             refr_q [NUM_NEURONS];
    logic [1:0]             refr_wr;
`endif

    assign step_accept = (state == S_IDLE) && bus.step_valid;

    snn_lif_core #(.VW(VW)) u_core (
        .v         (v_mem[idx]),
        .i_cur     (cur_shadow[idx]),
        .threshold (thr_q),
        .leak      (leak_q),
        .v_next    (core_v_next),
        .spike     (core_spike)
    );

    // Write-back value, spike bit and working spike vector for neuron idx.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        v_wr      = core_spike ? '0 : core_v_next;
        spike_bit = core_spike;
`ifdef SNN_REFRACTORY_EN
        refr_wr   = refr_q[idx];
        if (refr_q[idx] != 2'd0) begin
            v_wr      = '0;
            spike_bit = 1'b0;
            refr_wr   = refr_q[idx] - 2'd1;
        end else if (core_spike) begin
            refr_wr   = REFRACTORY_LEN;
        end
`endif
        work_next      = work_q;
        work_next[idx] = spike_bit;
    end

    // FSM, neuron index, config registers and spike vectors.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            thr_q    <= RST_THRESHOLD;
            leak_q   <= RST_LEAK;
            work_q   <= '0;
            spikes_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Config written together with a step is seen by that step.
                    if (bus.cfg_we) begin
                        thr_q  <= bus.cfg_threshold;
                        leak_q <= bus.cfg_leak;
                    end
                    if (step_accept) begin
                        state  <= S_UPDATE;
                        idx    <= '0;
                        work_q <= '0;
                    end
                end
                S_UPDATE: begin
                    work_q <= work_next;
                    if (idx == LAST_IDX) begin
                        state    <= S_DONE;
                        idx      <= '0;
                        spikes_q <= work_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Membrane potential register file; reset aborts and clears all neurons.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i] <= '0;
            end
        end else if (state == S_UPDATE) begin
            v_mem[idx] <= v_wr;
        end
    end

    // Shadow copy of the input currents taken when a step is accepted.
    always_ff @(posedge clk) begin
        // NOTE: the shadow is pure data, always rewritten before it is read,
        // so it carries no reset; the potentials above are state and do.
        if (step_accept) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cur_shadow[i] <= bus.current[i*VW +: VW];
            end
        end
    end

`ifdef SNN_REFRACTORY_EN
    // Per-neuron refractory counters, updated alongside the potentials.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                refr_q[i] <= 2'd0;
            end
        end else if (state == S_UPDATE) begin
            refr_q[idx] <= refr_wr;
        end
    end
`endif

    assign bus.step_ready = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.spikes     = spikes_q;

endmodule : snn_neuron_scheduler
